eth_tx_arbiter: RTL and testbench

//  Shares the single Ethernet TX byte stream (into preamble/FCS framer + MAC) between N_REQ frame sources
//  (ARP responder, UDP sender, ...). Whole frames granted round-robin; frames never interleaved.

---
 rtl/eth_types_pkg.sv | 14 +
 rtl/eth_rr_picker.sv | 29 ++
 rtl/eth_tx_arbiter.sv | 120 ++++++++++++
 tb/tb_eth_tx_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_types_pkg.sv
// Shared Ethernet TX types: arbiter state encoding and frame-level defaults.
package eth_types_pkg;

  localparam int ETH_IFG_BYTES       = 12;
  localparam int ETH_MAX_FRAME_BYTES = 1514;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_STREAM,
    ARB_DRAIN,
    ARB_IFG
  } tx_arb_states;

endpackage

// File: rtl/eth_rr_picker.sv
// Round-robin picker: first asserted request at or after rr_ptr, wrapping mod N_REQ.
module eth_rr_picker #(
  parameter  int N_REQ = 2,
  localparam int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic             any_req,
  output logic [PTR_W-1:0] grant
);

  int idx;

  // Scan from the far end so the candidate closest to rr_ptr is written last and wins.
  always_comb begin
    any_req = 1'b0;
    grant   = '0;
    idx     = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req[idx]) begin
        any_req = 1'b1;
        grant   = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Whole-frame round-robin arbiter onto the single TX byte stream, with IFG insertion
// and truncation of oversize frames (remainder drained from the source).
module eth_tx_arbiter
  import eth_types_pkg::*;
#(
  parameter  int N_REQ           = 2,
  parameter  int DATA_W          = 8,
  parameter  int IFG_BYTES       = ETH_IFG_BYTES,
  parameter  int MAX_FRAME_BYTES = ETH_MAX_FRAME_BYTES,
  localparam int PTR_W           = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    tx_valid,
  output logic [DATA_W-1:0]       tx_data,
  output logic                    tx_last,
  input  logic                    tx_ready,
  output logic [PTR_W-1:0]        grant_idx,
  output logic                    busy,
  output logic                    err_oversize
);

  localparam int CNT_W = $clog2(MAX_FRAME_BYTES + 1);
  localparam int IFG_W = (IFG_BYTES > 1) ? $clog2(IFG_BYTES) : 1;
  localparam tx_arb_states AFTER_FRAME = (IFG_BYTES == 0) ? ARB_IDLE : ARB_IFG;

  tx_arb_states      state, state_nxt;
  logic [PTR_W-1:0]  rr_ptr, rr_next, pick_idx;
  logic              any_req;
  logic [CNT_W-1:0]  byte_cnt;
  logic [IFG_W-1:0]  ifg_cnt;
  logic [DATA_W-1:0] req_bytes [N_REQ];
  logic              g_valid, g_last, beat, at_max, ifg_done, frame_end;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign req_bytes[i] = req_data[i*DATA_W +: DATA_W];
  end

  eth_rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req     (req_valid),
    .rr_ptr  (rr_ptr),
    .any_req (any_req),
    .grant   (pick_idx)
  );

  assign g_valid   = req_valid[grant_idx];
  assign g_last    = req_last[grant_idx];
  assign beat      = g_valid & req_ready[grant_idx];
  assign at_max    = (byte_cnt == CNT_W'(MAX_FRAME_BYTES - 1));
  assign ifg_done  = (ifg_cnt == IFG_W'(IFG_BYTES - 1));
  assign frame_end = beat & g_last & ((state == ARB_STREAM) | (state == ARB_DRAIN));
  assign rr_next   = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ARB_IDLE:   if (any_req) state_nxt = ARB_STREAM;
      ARB_STREAM: if (beat) begin
                    if (g_last)      state_nxt = AFTER_FRAME;
                    else if (at_max) state_nxt = ARB_DRAIN;
                  end
      ARB_DRAIN:  if (beat && g_last) state_nxt = AFTER_FRAME;
      ARB_IFG:    if (ifg_done) state_nxt = ARB_IDLE;
      default:    state_nxt = ARB_IDLE;
    endcase
  end

  // The granted source is wired straight through; a truncation beat gets tx_last forced.
  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = '0;
    tx_last   = 1'b0;
    req_ready = '0;
    unique case (state)
      ARB_STREAM: begin
        tx_valid             = g_valid;
        req_ready[grant_idx] = tx_ready;
        if (g_valid) begin
          tx_data = req_bytes[grant_idx];
          tx_last = g_last | at_max;
        end
      end
      ARB_DRAIN: req_ready[grant_idx] = 1'b1;
      default: ;
    endcase
  end

  assign busy = (state != ARB_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_idx    <= '0;
      rr_ptr       <= '0;
      byte_cnt     <= '0;
      ifg_cnt      <= '0;
      err_oversize <= 1'b0;
    end else begin
      err_oversize <= (state == ARB_STREAM) & beat & ~g_last & at_max;
      if (state == ARB_IDLE && any_req) begin
        grant_idx <= pick_idx;
        byte_cnt  <= '0;
      end else if (state == ARB_STREAM && beat && !g_last && !at_max) begin
        byte_cnt <= byte_cnt + CNT_W'(1);
      end
      if (frame_end) rr_ptr <= rr_next;
      if (state == ARB_IFG && !ifg_done) ifg_cnt <= ifg_cnt + IFG_W'(1);
      else                               ifg_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench for eth_tx_arbiter: per-source byte queues drive the requesters and
// the tx stream is checked against the frames each source was expected to deliver.
module tb_eth_tx_arbiter;

  localparam int MAXB = 1514;
  localparam int IFG  = 12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_last, req_ready;
  logic [15:0] req_data;
  logic        tx_valid, tx_last, tx_ready, grant_idx, busy, err_oversize;
  logic [7:0]  tx_data;

  logic [1:0]  z_req_valid, z_req_last, z_req_ready;
  logic [15:0] z_req_data;
  logic        z_tx_valid, z_tx_last, z_tx_ready, z_grant_idx, z_busy, z_err_oversize;
  logic [7:0]  z_tx_data;

  always #5 clk = ~clk;

  eth_tx_arbiter u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_last(tx_last), .tx_ready(tx_ready), .grant_idx(grant_idx), .busy(busy),
    .err_oversize(err_oversize)
  );

  eth_tx_arbiter #(.IFG_BYTES(0)) u_dut_nogap (
    .clk(clk), .rst_n(rst_n), .req_valid(z_req_valid), .req_data(z_req_data),
    .req_last(z_req_last), .req_ready(z_req_ready), .tx_valid(z_tx_valid), .tx_data(z_tx_data),
    .tx_last(z_tx_last), .tx_ready(z_tx_ready), .grant_idx(z_grant_idx), .busy(z_busy),
    .err_oversize(z_err_oversize)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  logic [8:0] src_q [2][$];
  logic [8:0] exp_q [2][$];
  int owner_q[$], first_cyc[$], end_cyc[$];
  int cyc, tx_beats, byte_bad, err_pulses, grant_bad, zero_bad, gap_cnt, last_gap;
  int req_beats [2];
  int bubble_pct, stall_pct;
  bit in_frame, gap_open;
  logic frame_g;

  task automatic clear_stats();
    owner_q.delete(); first_cyc.delete(); end_cyc.delete();
    tx_beats = 0; byte_bad = 0; err_pulses = 0; grant_bad = 0; zero_bad = 0;
    gap_cnt = 0; last_gap = -1; req_beats[0] = 0; req_beats[1] = 0;
    in_frame = 0; gap_open = 0;
  endtask

  task automatic load_frame(input int src, input int len, input int seed);
    logic [7:0] d;
    for (int k = 0; k < len; k++) begin
      d = 8'(seed + k);
      src_q[src].push_back({(k == len - 1), d});
      if (k < MAXB) exp_q[src].push_back({(k == len - 1) || (k == MAXB - 1), d});
    end
  endtask

  task automatic step();
    logic [8:0] ent, want;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (src_q[i].size() > 0 && $urandom_range(99) >= bubble_pct) begin
        ent = src_q[i][0];
        req_valid[i] = 1'b1;
        req_last[i]  = ent[8];
        req_data[i*8 +: 8] = ent[7:0];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
        req_data[i*8 +: 8] = 8'h00;
      end
    end
    tx_ready = ($urandom_range(99) >= stall_pct);
    #1;
    cyc++;
    if (!tx_valid && (tx_data !== 8'h00 || tx_last !== 1'b0)) zero_bad++;
    if (err_oversize) err_pulses++;
    if (gap_open) begin
      if (busy) gap_cnt++;
      else begin
        gap_open = 0;
        last_gap = gap_cnt;
      end
    end
    if (tx_valid && tx_ready) begin
      tx_beats++;
      if (!in_frame) begin
        in_frame = 1;
        frame_g  = grant_idx;
        first_cyc.push_back(cyc);
      end else if (grant_idx !== frame_g) grant_bad++;
      if (exp_q[grant_idx].size() == 0) byte_bad++;
      else begin
        want = exp_q[grant_idx].pop_front();
        if ({tx_last, tx_data} !== want) byte_bad++;
      end
      if (tx_last) begin
        in_frame = 0;
        owner_q.push_back(int'(grant_idx));
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        req_beats[i]++;
        ent = src_q[i].pop_front();
        if (ent[8]) begin
          end_cyc.push_back(cyc);
          gap_open = 1;
          gap_cnt  = 0;
        end
      end
    end
  endtask

  task automatic run(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (n < budget && !(src_q[0].size() == 0 && src_q[1].size() == 0 && !busy));
    if (n >= budget) check({tag, "_timeout"}, 1, 0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0; tx_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_stats();
  endtask

  initial begin
    int start, n, zbad, zbeats, a_last, b_first;
    logic [8:0] zq[$];
    logic [8:0] zw;
    cyc = 0; bubble_pct = 0; stall_pct = 0;
    z_req_valid = '0; z_req_last = '0; z_req_data = '0; z_tx_ready = 1'b1;
    rst_n = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0; tx_ready = 1'b1;
    clear_stats();
    #12;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_last", tx_last, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_grant", grant_idx, 0);
    check("rst_err", err_oversize, 0);
    apply_reset();

    // single 60-byte frame from req0
    load_frame(0, 60, 8'h01);
    start = cyc + 1;
    run("s1", 300);
    check("s1_bytes_bad", byte_bad, 0);
    check("s1_beats", tx_beats, 60);
    check("s1_owner", owner_q.size() == 1 ? owner_q[0] : -1, 0);
    check("s1_latency", first_cyc.size() > 0 ? first_cyc[0] - start : -1, 1);
    check("s1_ifg", last_gap, IFG);
    check("s1_zero_idle", zero_bad, 0);

    // simultaneous requests after reset, then a second pair
    apply_reset();
    load_frame(0, 20, 8'h10);
    load_frame(1, 20, 8'h90);
    run("s2a", 300);
    load_frame(0, 20, 8'h30);
    load_frame(1, 20, 8'hB0);
    run("s2b", 300);
    check("s2_bytes_bad", byte_bad, 0);
    check("s2_nframes", owner_q.size(), 4);
    if (owner_q.size() == 4) begin
      check("s2_owner0", owner_q[0], 0);
      check("s2_owner1", owner_q[1], 1);
      check("s2_owner2", owner_q[2], 0);
      check("s2_owner3", owner_q[3], 1);
    end
    check("s2_gap_first", (first_cyc.size() > 1 && end_cyc.size() > 0) ? first_cyc[1] - end_cyc[0] : -1, IFG + 2);

    // stalls and bubbles, mixed frame lengths including a one-byte frame
    clear_stats();
    bubble_pct = 25; stall_pct = 30;
    load_frame(0, 5, 8'h00);  load_frame(0, 17, 8'h20); load_frame(0, 33, 8'h40);
    load_frame(1, 9, 8'h80);  load_frame(1, 1, 8'hC0);  load_frame(1, 40, 8'hD0);
    run("s3", 3000);
    check("s3_bytes_bad", byte_bad, 0);
    check("s3_beats", tx_beats, 105);
    check("s3_src0_beats", req_beats[0], 55);
    check("s3_src1_beats", req_beats[1], 50);
    check("s3_grant_stable", grant_bad, 0);
    check("s3_nframes", owner_q.size(), 6);
    check("s3_zero_idle", zero_bad, 0);
    check("s3_exp_left", exp_q[0].size() + exp_q[1].size(), 0);
    bubble_pct = 0; stall_pct = 0;

    // oversize frame from req1
    apply_reset();
    load_frame(1, 1600, 8'h33);
    run("s4", 2500);
    check("s4_bytes_bad", byte_bad, 0);
    check("s4_beats", tx_beats, MAXB);
    check("s4_err_pulses", err_pulses, 1);
    check("s4_drained", req_beats[1] - tx_beats, 86);
    check("s4_nframes", owner_q.size(), 1);
    check("s4_ifg", last_gap, IFG);
    check("s4_busy_end", busy, 0);

    // reset in the middle of a frame
    apply_reset();
    load_frame(0, 40, 8'h50);
    n = 0;
    while (tx_beats < 20 && n < 200) begin
      step();
      n++;
    end
    check("s6_reached_20", tx_beats, 20);
    #1 rst_n = 1'b0;
    #1;
    check("s6_tx_valid", tx_valid, 0);
    check("s6_req_ready", req_ready, 0);
    check("s6_busy", busy, 0);
    check("s6_grant", grant_idx, 0);
    for (int i = 0; i < 2; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
    end
    req_valid = '0; req_last = '0; req_data = '0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_stats();
    load_frame(1, 10, 8'hE0);
    run("s6", 200);
    check("s6_owner", owner_q.size() == 1 ? owner_q[0] : -1, 1);
    check("s6_bytes_bad", byte_bad, 0);
    check("s6_beats", tx_beats, 10);

    // zero-gap instance: back-to-back frames from req0
    for (int k = 0; k < 3; k++) zq.push_back({(k == 2), 8'(8'hA0 + k)});
    for (int k = 0; k < 3; k++) zq.push_back({(k == 2), 8'(8'hB0 + k)});
    zbad = 0; zbeats = 0; a_last = -1; b_first = -1;
    for (int c = 0; c < 60 && zq.size() > 0; c++) begin
      @(negedge clk);
      z_req_valid[0] = 1'b1;
      z_req_last[0]  = zq[0][8];
      z_req_data[7:0] = zq[0][7:0];
      #1;
      if (z_tx_valid && z_tx_ready) begin
        zw = zq.pop_front();
        if ({z_tx_last, z_tx_data} !== zw) zbad++;
        if (zbeats == 2) a_last = c;
        if (zbeats == 3) b_first = c;
        zbeats++;
      end
    end
    @(negedge clk);
    z_req_valid = '0; z_req_last = '0; z_req_data = '0;
    check("s5_beats", zbeats, 6);
    check("s5_bytes_bad", zbad, 0);
    check("s5_b2b_spacing", b_first - a_last, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
